// File: rtl/music_pkg.sv
// Shared note encoding, half-period table and melody contents for the music box.
// The melody is a pure function of the index, so it synthesises to a small combinational ROM.
package music_pkg;

    localparam logic [3:0] NOTE_C    = 4'd0;
    localparam logic [3:0] NOTE_CS   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_DS   = 4'd3;
    localparam logic [3:0] NOTE_E    = 4'd4;
    localparam logic [3:0] NOTE_F    = 4'd5;
    localparam logic [3:0] NOTE_FS   = 4'd6;
    localparam logic [3:0] NOTE_G    = 4'd7;
    localparam logic [3:0] NOTE_GS   = 4'd8;
    localparam logic [3:0] NOTE_A    = 4'd9;
    localparam logic [3:0] NOTE_AS   = 4'd10;
    localparam logic [3:0] NOTE_B    = 4'd11;
    localparam logic [3:0] NOTE_REST = 4'd12;

    typedef struct packed {
        logic [1:0] octave;
        logic [3:0] note;
    } note_t;

    // Octave-0 half periods in clocks at 12.5 MHz; codes 12..15 are rests and never sound.
    localparam logic [14:0] HP_TABLE [16] = '{
        15'd23889, 15'd22549, 15'd21283, 15'd20088,
        15'd18961, 15'd17897, 15'd16892, 15'd15944,
        15'd15049, 15'd14205, 15'd13407, 15'd12655,
        15'd0,     15'd0,     15'd0,     15'd0
    };

    function automatic logic [14:0] half_period(input note_t e);
        return HP_TABLE[e.note] >> e.octave;
    endfunction

    function automatic logic is_rest(input note_t e);
        return e.note >= NOTE_REST;
    endfunction

    function automatic note_t melody_rom(input logic [7:0] idx);
        note_t e;
        case (idx)
            8'd0:    e = '{2'd0, NOTE_A};
            8'd1:    e = '{2'd1, NOTE_C};
            8'd2:    e = '{2'd0, NOTE_REST};
            8'd3:    e = '{2'd2, NOTE_E};
            8'd4:    e = '{2'd1, NOTE_E};
            8'd5:    e = '{2'd1, NOTE_F};
            8'd6:    e = '{2'd1, NOTE_G};
            8'd7:    e = '{2'd1, NOTE_G};
            8'd8:    e = '{2'd1, NOTE_F};
            8'd9:    e = '{2'd1, NOTE_E};
            8'd10:   e = '{2'd1, NOTE_D};
            8'd11:   e = '{2'd1, NOTE_C};
            8'd12:   e = '{2'd1, NOTE_C};
            8'd13:   e = '{2'd1, NOTE_D};
            8'd14:   e = '{2'd1, NOTE_E};
            8'd15:   e = '{2'd1, NOTE_E};
            8'd16:   e = '{2'd1, NOTE_D};
            8'd17:   e = '{2'd1, NOTE_D};
            8'd18:   e = '{2'd0, NOTE_REST};
            8'd19:   e = '{2'd1, NOTE_E};
            8'd20:   e = '{2'd1, NOTE_E};
            8'd21:   e = '{2'd1, NOTE_F};
            8'd22:   e = '{2'd1, NOTE_G};
            8'd23:   e = '{2'd1, NOTE_G};
            8'd24:   e = '{2'd1, NOTE_F};
            8'd25:   e = '{2'd1, NOTE_E};
            8'd26:   e = '{2'd1, NOTE_D};
            8'd27:   e = '{2'd1, NOTE_C};
            8'd28:   e = '{2'd1, NOTE_C};
            8'd29:   e = '{2'd1, NOTE_D};
            8'd30:   e = '{2'd1, NOTE_E};
            8'd31:   e = '{2'd1, NOTE_D};
            default: e = '{2'd0, NOTE_REST};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/music_box_if.sv
// Audio output bundle: the player drives the speaker line, the board/bench listens.
interface music_box_if;
    logic speaker;

    modport master (output speaker);
    modport slave  (input  speaker);
endinterface

// File: rtl/music_tone_gen.sv
// Square-wave generator: toggles the speaker every half_period clocks, silenced by mute or restart.
module music_tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [14:0] half_period,
    input  logic        mute,
    output logic        speaker
);

    logic [14:0] tc;

    // NOTE: state registers use <= so every flop samples pre-edge values; = here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst || restart || mute) begin
            tc      <= '0;
            speaker <= 1'b0;
        end else if (tc == half_period - 15'd1) begin
            tc      <= '0;
            speaker <= ~speaker;
        end else begin
            tc <= tc + 15'd1;
        end
    end

endmodule

// File: rtl/music_box.sv
// Melody sequencer: holds each ROM note for NOTE_CYCLES clocks, loops forever, and feeds the tone generator.
module music_box
    import music_pkg::*;
#(
    parameter int NOTE_CYCLES = 2_500_000,
    parameter int ROM_DEPTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    music_box_if.master audio
);

    localparam int DC_W  = $clog2(NOTE_CYCLES);
    localparam int IDX_W = $clog2(ROM_DEPTH);

    logic [DC_W-1:0]  dc;
    logic [IDX_W-1:0] idx;
    logic             boundary;
    note_t            cur;

    // NOTE: the melody is a constant lookup with no storage, so there is nothing to reset; only dc and idx are state.
    always_comb begin
        cur = melody_rom(8'(idx));
    end

    assign boundary = (dc == DC_W'(NOTE_CYCLES - 1));

    // idx wraps naturally because ROM_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc  <= '0;
            idx <= '0;
        end else if (boundary) begin
            dc  <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            dc <= dc + DC_W'(1);
        end
    end

    music_tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .restart     (boundary),
        .half_period (half_period(cur)),
        .mute        (is_rest(cur)),
        .speaker     (audio.speaker)
    );

endmodule

// File: tb/tb_music_box.sv
// Bench for music_box: two instances share the clock; one plays a full loop plus wrap,
// the other is reset at a random point in entry 1 and must restart entry-0 timing.
module tb_music_box;

    localparam int NC    = 14400;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    music_box_if if_a ();
    music_box_if if_b ();

    music_box #(.NOTE_CYCLES(NC), .ROM_DEPTH(DEPTH)) dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .audio (if_a)
    );

    music_box #(.NOTE_CYCLES(NC), .ROM_DEPTH(DEPTH)) dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .audio (if_b)
    );

    always #40 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference tune: octave-0 half periods and the four fixed opening entries (note 12 = rest).
    int hp_tab   [12] = '{23889, 22549, 21283, 20088, 18961, 17897,
                          16892, 15944, 15049, 14205, 13407, 12655};
    int mel_note [4]  = '{9, 0, 12, 4};
    int mel_oct  [4]  = '{0, 1, 0, 2};

    int rises_a[$];
    int rises_b[$];
    int exp_a[$];
    int exp_b[$];

    // Expected speaker level after the n-th clock edge since reset was released.
    function automatic logic model_spk(input int n);
        int ix;
        int off;
        int hpe;
        ix  = (n / NC) % DEPTH;
        off = n % NC;
        if (mel_note[ix] >= 12) return 1'b0;
        hpe = hp_tab[mel_note[ix]] >> mel_oct[ix];
        return ((off / hpe) % 2) == 1;
    endfunction

    task automatic check_span(input string name, input int first, input int last, input bit use_b);
        int   win_bad;
        int   bad_n;
        logic bad_obs;
        logic bad_exp;
        logic prev;
        logic obs;
        logic exp_v;
        win_bad = 0;
        bad_n   = -1;
        bad_obs = 1'b0;
        bad_exp = 1'b0;
        prev    = 1'b0;
        for (int n = first; n <= last; n++) begin
            @(negedge clk);
            obs   = use_b ? if_b.speaker : if_a.speaker;
            exp_v = model_spk(n);
            if (obs !== exp_v) begin
                if (win_bad == 0) begin
                    bad_n   = n;
                    bad_obs = obs;
                    bad_exp = exp_v;
                end
                win_bad++;
            end
            if (prev === 1'b0 && obs === 1'b1) begin
                if (use_b) rises_b.push_back(n);
                else       rises_a.push_back(n);
            end
            prev = obs;
            if ((n % NC) == NC - 1 || n == last) begin
                compared++;
                if (win_bad != 0) begin
                    mismatched++;
                    $display("FAIL %s window to edge %0d: speaker=%b at edge %0d, expected %b (%0d bad cycles)",
                             name, n, bad_obs, bad_n, bad_exp, win_bad);
                end
                win_bad = 0;
            end
        end
    endtask

    task automatic compare_rises(input string name, input bit use_b);
        int got[$];
        int want[$];
        if (use_b) begin
            got  = rises_b;
            want = exp_b;
        end else begin
            got  = rises_a;
            want = exp_a;
        end
        compared++;
        if (got.size() != want.size()) begin
            mismatched++;
            $display("FAIL %s count: got %0d rising edges, expected %0d", name, got.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                compared++;
                if (got[i] != want[i]) begin
                    mismatched++;
                    $display("FAIL %s[%0d]: rise at edge %0d, expected %0d", name, i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared += 2;
            if (if_a.speaker !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_a cycle %0d: speaker=%b, expected 0", i, if_a.speaker);
            end
            if (if_b.speaker !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_b cycle %0d: speaker=%b, expected 0", i, if_b.speaker);
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        compared += 2;
        if (if_a.speaker !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_a: speaker=%b, expected 0", if_a.speaker);
        end
        if (if_b.speaker !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_b: speaker=%b, expected 0", if_b.speaker);
        end
    endtask

    // Full melody loop plus the repeat of entry 0 after the wrap.
    task automatic test_playback();
        check_span("a_loop", 2, DEPTH * NC + NC - 1, 1'b0);
        exp_a = '{14205, NC + 11944, 3 * NC + 4740, 3 * NC + 3 * 4740, DEPTH * NC + 14205};
        compare_rises("a_rises", 1'b0);
    endtask

    task automatic test_midnote_reset();
        int rst_pt;
        int len;
        rst_pt = NC + int'($urandom_range(1, NC - 2));
        len    = int'($urandom_range(1, 4));
        check_span("b_pre", 2, rst_pt, 1'b1);
        exp_b = '{14205};
        if (rst_pt >= NC + 11944) exp_b.push_back(NC + 11944);
        compare_rises("b_pre_rises", 1'b1);

        rst_b = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            compared++;
            if (if_b.speaker !== 1'b0) begin
                mismatched++;
                $display("FAIL b_mid_reset cycle %0d (reset at edge %0d): speaker=%b, expected 0",
                         i, rst_pt, if_b.speaker);
            end
        end
        rst_b = 1'b0;

        rises_b.delete();
        check_span("b_restart", 1, NC + 300, 1'b1);
        exp_b = '{14205};
        compare_rises("b_restart_rises", 1'b1);
    endtask

    initial begin
        test_reset();
        fork
            test_playback();
            test_midnote_reset();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
